// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the sequence detector input `a`, one word buffered in a holding register.
// Latency: word accepted at edge E0, first bit on `a` after E1, last bit after E(WIDTH); gapless when hold is refilled in time.
// Backpressure: din_ready low from the accept edge until the held word moves into the shift register, and during reset.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a,
  output logic             a_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sreg;
  logic             active;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             load;

  // The last bit of the current word is on `a`; a held word may replace it next edge.
  assign last_bit = active && (cnt == LAST_IDX);
  // Move the held word into the shifter when idle or exactly as the current word ends.
  assign load     = hold_full && (!active || last_bit);
  // Accept and load are mutually exclusive: one needs hold empty, the other hold full.
  assign accept   = din_valid && din_ready;

  // Holding register, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      sreg      <= '0;
      active    <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end

      if (load) begin
        sreg      <= hold;
        cnt       <= '0;
        active    <= 1'b1;
        hold_full <= 1'b0;
      end else if (active && !last_bit) begin
        cnt  <= cnt + CW'(1);
        sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      end else if (last_bit) begin
        active <= 1'b0;
        cnt    <= '0;
      end
    end
  end

  // Ready depends on rst so nothing is taken on a reset edge; everything else comes from state.
  assign din_ready = !hold_full && !rst;
  assign a         = active ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;
  assign a_valid   = active;
  assign word_done = last_bit;
  assign busy      = active || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;

  logic clk = 1'b0;
  logic rst;

  // u0: WIDTH=8, MSB first, idle high
  logic [7:0] din0;
  logic       vld0, rdy0, a0, av0, wd0, busy0;
  // u1: WIDTH=8, LSB first, idle high
  logic [7:0] din1;
  logic       vld1, rdy1, a1, av1, wd1, busy1;
  // u2: WIDTH=8, MSB first, idle low
  logic [7:0] din2;
  logic       vld2, rdy2, a2, av2, wd2, busy2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(vld0), .din_ready(rdy0),
    .a(a0), .a_valid(av0), .word_done(wd0), .busy(busy0)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(vld1), .din_ready(rdy1),
    .a(a1), .a_valid(av1), .word_done(wd1), .busy(busy1)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(vld2), .din_ready(rdy2),
    .a(a2), .a_valid(av2), .word_done(wd2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  seq;
    logic [7:0]  words [3];
    logic [23:0] stream;
    int          idx;
    logic        acc;

    rst  = 1'b1;
    din0 = 8'h00; vld0 = 1'b0;
    din1 = 8'h00; vld1 = 1'b0;
    din2 = 8'h00; vld2 = 1'b0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    chk("rst_ready_low", rdy0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_a_idle", a0, 1'b1);
    chk("rst_av", av0, 1'b0);
    chk("rst_wd", wd0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ready_high", rdy0, 1'b1);
    chk("rst_a_idle_u2", a2, 1'b0);

    // ---------------- 1: single word 0x71 ----------------
    seq  = 8'b0111_0001;          // expected order on a: 0,1,1,1,0,0,0,1
    din0 = 8'h71; vld0 = 1'b1;
    tick();                       // E0: accepted
    vld0 = 1'b0;
    chk("s1_av_after_accept", av0, 1'b0);
    chk("s1_a_idle_before", a0, 1'b1);
    chk("s1_busy_held", busy0, 1'b1);
    chk("s1_ready_low", rdy0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("s1_a_bit%0d", i), a0, seq[7-i]);
      chk($sformatf("s1_av_bit%0d", i), av0, 1'b1);
      chk($sformatf("s1_wd_bit%0d", i), wd0, (i == 7));
    end
    tick();
    chk("s1_av_after", av0, 1'b0);
    chk("s1_a_after", a0, 1'b1);
    chk("s1_busy_after", busy0, 1'b0);

    // ---------------- 2: back-to-back 0x71, 0xA5, 0x0F ----------------
    words[0] = 8'h71; words[1] = 8'hA5; words[2] = 8'h0F;
    stream   = 24'b0111_0001_1010_0101_0000_1111;
    idx  = 0;
    din0 = words[0]; vld0 = 1'b1;
    for (int c = 0; c < 26; c++) begin
      acc = vld0 && rdy0;
      tick();                     // after E_c
      if (acc) begin
        idx++;
        if (idx < 3) din0 = words[idx];
        else         vld0 = 1'b0;
      end
      if (c >= 1 && c <= 24) begin
        chk($sformatf("s2_av_c%0d", c), av0, 1'b1);
        chk($sformatf("s2_a_c%0d", c), a0, stream[24-c]);
        chk($sformatf("s2_wd_c%0d", c), wd0, (c % 8 == 0));
      end
      if (c == 0 || c == 2 || c == 5 || c == 10) chk($sformatf("s2_ready_low_c%0d", c), rdy0, 1'b0);
      if (c == 1 || c == 9 || c == 17) chk($sformatf("s2_ready_high_c%0d", c), rdy0, 1'b1);
      if (c == 25) begin
        chk("s2_av_end", av0, 1'b0);
        chk("s2_a_end", a0, 1'b1);
        chk("s2_busy_end", busy0, 1'b0);
      end
    end

    // ---------------- 4: 0xFF, 5-cycle gap, 0x00 ----------------
    din0 = 8'hFF; vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("s4_ff_a%0d", i), a0, 1'b1);
      chk($sformatf("s4_ff_av%0d", i), av0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("s4_gap_av%0d", i), av0, 1'b0);
      chk($sformatf("s4_gap_a%0d", i), a0, 1'b1);
    end
    din0 = 8'h00; vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    chk("s4_zero_av_accept", av0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("s4_00_a%0d", i), a0, 1'b0);
      chk($sformatf("s4_00_av%0d", i), av0, 1'b1);
      chk($sformatf("s4_00_wd%0d", i), wd0, (i == 7));
    end
    tick();
    chk("s4_idle_after", a0, 1'b1);

    // ---------------- 5: reset mid-word ----------------
    din0 = 8'h71; vld0 = 1'b1;
    tick();                       // E0: 0x71 accepted
    din0 = 8'hA5;
    tick();                       // E1: 0x71 loaded, bit 0
    chk("s5_bit0", a0, 1'b0);
    tick();                       // E2: 0xA5 accepted, bit 1
    vld0 = 1'b0;
    chk("s5_bit1", a0, 1'b1);
    tick();                       // E3: bit 2
    chk("s5_bit2", a0, 1'b1);
    rst = 1'b1;
    #1;
    chk("s5_ready_in_rst", rdy0, 1'b0);
    tick();                       // reset edge
    rst = 1'b0;
    #1;
    chk("s5_a_idle", a0, 1'b1);
    chk("s5_av", av0, 1'b0);
    chk("s5_wd", wd0, 1'b0);
    chk("s5_busy", busy0, 1'b0);
    chk("s5_ready", rdy0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("s5_no_data_av%0d", i), av0, 1'b0);
      chk($sformatf("s5_no_data_a%0d", i), a0, 1'b1);
    end

    // ---------------- 3: LSB first, 0x8E ----------------
    seq  = 8'b0111_0001;          // 0x8E sent bit 0 first: 0,1,1,1,0,0,0,1
    din1 = 8'h8E; vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    chk("s3_av_accept", av1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("s3_a_bit%0d", i), a1, seq[7-i]);
      chk($sformatf("s3_av_bit%0d", i), av1, 1'b1);
      chk($sformatf("s3_wd_bit%0d", i), wd1, (i == 7));
    end
    tick();
    chk("s3_av_after", av1, 1'b0);
    chk("s3_a_after", a1, 1'b1);

    // ---------------- 6: idle low, then 0x80 ----------------
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("s6_idle_a%0d", i), a2, 1'b0);
      chk($sformatf("s6_idle_av%0d", i), av2, 1'b0);
    end
    din2 = 8'h80; vld2 = 1'b1;
    tick();
    vld2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("s6_a_bit%0d", i), a2, (i == 0));
      chk($sformatf("s6_av_bit%0d", i), av2, 1'b1);
    end
    tick();
    chk("s6_av_after", av2, 1'b0);
    chk("s6_a_after", a2, 1'b0);
    chk("s6_busy_after", busy2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the serial sequence detector and drives its single-bit input `a`. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts each word out one bit per clock, so consecutive words stream with no gap. Between words it drives a fixed idle level, so the detector never sees spurious data.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1: bit WIDTH-1 sent first; 0: bit 0 sent first
IDLE_BIT, 1, level driven on `a` while no word is being shifted

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
din  input  WIDTH  parallel word
din_valid  input  1  din holds a valid word
din_ready  output  1  block can accept a word this cycle
a  output  1  serial bit to the detector
a_valid  output  1  `a` carries a data bit this cycle
word_done  output  1  `a` carries the last bit of a word this cycle
busy  output  1  a word is shifting or is held

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- State:
  - hold[WIDTH-1:0], hold_full
  - sreg[WIDTH-1:0], active
  - cnt, width clog2(WIDTH)
- All outputs are functions of registered state only, except din_ready, which also includes rst. There is no din-to-a combinational path.
- din_ready = !hold_full && !rst. A word is accepted on an edge where din_valid && din_ready; then hold <= din and hold_full <= 1.
- Load condition: hold_full && (!active || cnt==WIDTH-1).
  - On load: sreg <= hold, cnt <= 0, active <= 1, hold_full <= 0.
  - Accept and load never coincide, because load requires hold_full and accept requires !hold_full.
- Shifting (active && cnt!=WIDTH-1):
  - cnt <= cnt+1.
  - MSB_FIRST=1: sreg shifts left.
  - MSB_FIRST=0: sreg shifts right.
- End of word (active && cnt==WIDTH-1, no load): active <= 0, cnt <= 0.
- Outputs:
  - a = active ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT.
  - a_valid = active.
  - word_done = active && cnt==WIDTH-1.
  - busy = active || hold_full.
- Latency: word accepted at edge E0 → first bit on `a` in the cycle after E1 → last bit in the cycle after E(WIDTH).
- Throughput: one word per WIDTH cycles. With hold refilled before the last bit, a_valid stays high continuously across words (gapless).
- Backpressure: din_ready is low from the accept edge until the load edge. A third word offered during back-to-back streaming stalls until hold empties. din must stay stable while din_valid && !din_ready.
- Reset (including mid-word):
  - On the edge with rst=1: hold_full=0, active=0, cnt=0, sreg=0.
  - Partial and held words are discarded.
  - From the following cycle: a=IDLE_BIT, a_valid=0, word_done=0, busy=0.
  - din_ready is 0 while rst is high and 1 after reset.
- din_valid while din_ready=0 has no effect. There is no X-propagation from din when din_valid=0.

Test Plan:
1. Single word: WIDTH=8, MSB_FIRST=1, accept 0x71 at E0 → `a` = 0,1,1,1,0,0,0,1 over the 8 cycles after E1, a_valid high for exactly those 8 cycles, word_done high only on the 8th; a=1 before and after. The downstream detector's match pulses one cycle after its state H.
2. Back-to-back: din_valid held with 0x71, then 0xA5, then 0x0F →
   - a_valid high for 24 consecutive cycles.
   - Bits are 0x71, 0xA5, 0x0F MSB-first.
   - word_done pulses on cycles 8, 16 and 24.
   - din_ready drops after each accept and stays low while hold is full.
3. LSB-first: MSB_FIRST=0, word 0x8E → `a` = 0,1,1,1,0,0,0,1, same as scenario 1.
4. Gap: one word 0xFF, then din_valid low for 5 cycles, then 0x00 → a=1 for 8 data cycles. During the gap a_valid=0 and a=IDLE_BIT. Then 8 zeros with a_valid=1.
5. Reset mid-word: assert rst for one cycle after 3 bits of 0x71, with 0xA5 held → next cycle a=IDLE_BIT, a_valid=0, busy=0, din_ready=1. Neither remaining 0x71 bits nor 0xA5 ever appear.
6. IDLE_BIT=0: no input for 10 cycles → a=0, a_valid=0 throughout. Then 0x80 → a=1, followed by 7 zeros.
